// File: rtl/mux_arb_n.sv
// N:1 stream merge with fixed-select or round-robin grant into a one-entry output register.
// Latency 1 cycle; a stalled output (out_valid & !out_ready) blocks all inputs until consumed.
module mux_arb_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;

    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] scan_idx;
    logic             grant_ok;
    logic             load_en;
    logic             accept;

    // Round-robin scan runs farthest-first so the nearest valid channel after ptr wins.
    always_comb begin
        grant    = sel;
        grant_ok = 1'b0;
        scan_idx = '0;
        if (!mode) begin
            if (int'(sel) < CHANNELS) begin
                grant_ok = in_valid[sel];
            end
        end else begin
            grant = ptr_q;
            for (int i = CHANNELS; i >= 1; i--) begin
                scan_idx = SEL_W'((int'(ptr_q) + i) % CHANNELS);
                if (in_valid[scan_idx]) begin
                    grant    = scan_idx;
                    grant_ok = 1'b1;
                end
            end
        end
    end

    assign load_en = !out_valid_q || out_ready;
    assign accept  = load_en && grant_ok && rst_n;

    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_data_d  = in_data[int'(grant)*WIDTH +: WIDTH];
            out_chan_d  = grant;
            out_valid_d = 1'b1;
            ptr_d       = grant;
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= SEL_W'(CHANNELS - 1);
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Self-checking bench for mux_arb_n (WIDTH=8, CHANNELS=4) using an expected-word queue.
module tb_mux_arb_n;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    typedef struct packed {
        logic [1:0] c;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [7:0] chd [4];
    int         errors;
    int         checks;

    mux_arb_n #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 4'h0;
        out_ready = 1'b1;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mode = 1'b1; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
        in_data = {chd[3], chd[2], chd[1], chd[0]};
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL rst_in_ready: got %b want 0000", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h want 00", out_data); end
        checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL rst_out_chan: got %0d want 0", out_chan); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b want 0001", in_ready); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_first_valid: got %b want 1", out_valid); end
        checks++; if ({out_chan, out_data} !== {2'd0, chd[0]}) begin errors++; $display("FAIL rst_first_word: got chan %0d data %h want chan 0 data %h", out_chan, out_data, chd[0]); end
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = {chd[3], 8'hA5 + 8'(i), chd[1], chd[0]};
            exp_q.push_back('{c: 2'd2, d: 8'hA5 + 8'(i)});
            #1;
            checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_in_ready: got %b want 0100", in_ready); end
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fixed_out_valid: got %b want 1", out_valid); end
            e = exp_q.pop_front();
            checks++;
            if ({out_chan, out_data} !== {e.c, e.d}) begin
                errors++; $display("FAIL fixed_word: got chan %0d data %h want chan %0d data %h", out_chan, out_data, e.c, e.d);
            end
        end
        in_valid = 4'h0;
    endtask

    task automatic test_rr();
        do_reset();
        mode = 1'b1; out_ready = 1'b1;
        in_data = {chd[3], chd[2], chd[1], chd[0]};
        foreach (chd[k]) begin end
        exp_q.push_back('{c: 2'd0, d: chd[0]});
        exp_q.push_back('{c: 2'd1, d: chd[1]});
        exp_q.push_back('{c: 2'd2, d: chd[2]});
        exp_q.push_back('{c: 2'd3, d: chd[3]});
        exp_q.push_back('{c: 2'd0, d: chd[0]});
        exp_q.push_back('{c: 2'd1, d: chd[1]});
        for (int i = 0; i < 7; i++) begin
            in_valid = (i < 6) ? 4'hF : 4'h0;
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rr_extra: got chan %0d want no word", out_chan);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_chan, out_data} !== {e.c, e.d}) begin
                        errors++; $display("FAIL rr_word: got chan %0d data %h want chan %0d data %h", out_chan, out_data, e.c, e.d);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_missing: got %0d words left want 0", exp_q.size()); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got out_valid %b want 0", out_valid); end
        exp_q.delete();
    endtask

    task automatic test_rr_sparse();
        do_reset();
        mode = 1'b1; out_ready = 1'b1;
        in_data = {chd[3], chd[2], chd[1], chd[0]};
        exp_q.push_back('{c: 2'd1, d: chd[1]});
        exp_q.push_back('{c: 2'd3, d: chd[3]});
        exp_q.push_back('{c: 2'd1, d: chd[1]});
        exp_q.push_back('{c: 2'd3, d: chd[3]});
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 4) ? 4'b1010 : 4'h0;
            #1;
            checks++; if ((in_ready & 4'b0101) !== 4'b0000) begin errors++; $display("FAIL sparse_idle_ready: got %b want x0x0", in_ready); end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL sparse_extra: got chan %0d want no word", out_chan);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_chan, out_data} !== {e.c, e.d}) begin
                        errors++; $display("FAIL sparse_word: got chan %0d data %h want chan %0d data %h", out_chan, out_data, e.c, e.d);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sparse_missing: got %0d words left want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic rdy_pat [7];
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        mode = 1'b1;
        in_data = {chd[3], chd[2], chd[1], chd[0]};
        exp_q.push_back('{c: 2'd0, d: chd[0]});
        exp_q.push_back('{c: 2'd1, d: chd[1]});
        exp_q.push_back('{c: 2'd2, d: chd[2]});
        for (int i = 0; i < 7; i++) begin
            in_valid  = (i < 6) ? 4'hF : 4'h0;
            out_ready = rdy_pat[i];
            #1;
            if (i >= 1 && i <= 3) begin
                checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL stall_in_ready: got %b want 0000", in_ready); end
                checks++;
                if ({out_valid, out_chan, out_data} !== {1'b1, 2'd0, chd[0]}) begin
                    errors++; $display("FAIL stall_hold: got v%b chan %0d data %h want v1 chan 0 data %h", out_valid, out_chan, out_data, chd[0]);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stall_extra: got chan %0d want no word", out_chan);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_chan, out_data} !== {e.c, e.d}) begin
                        errors++; $display("FAIL stall_word: got chan %0d data %h want chan %0d data %h", out_chan, out_data, e.c, e.d);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_missing: got %0d words left want 0", exp_q.size()); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got out_valid %b want 0", out_valid); end
        exp_q.delete();
    endtask

    task automatic test_no_grant_and_reset();
        do_reset();
        mode = 1'b0; sel = 2'd1; in_valid = 4'hF; out_ready = 1'b1;
        in_data = {chd[3], chd[2], chd[1], chd[0]};
        #1;
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL nogrant_first: got %b want 0010", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 4'b1101;
        #1;
        checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL nogrant_ready: got %b want 0000", in_ready); end
        checks++; if ({out_valid, out_chan} !== {1'b1, 2'd1}) begin errors++; $display("FAIL nogrant_word: got v%b chan %0d want v1 chan 1", out_valid, out_chan); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nogrant_drop: got out_valid %b want 0", out_valid); end
        checks++; if ({out_chan, out_data} !== {2'd1, chd[1]}) begin errors++; $display("FAIL nogrant_hold: got chan %0d data %h want chan 1 data %h", out_chan, out_data, chd[1]); end
        in_valid = 4'hF; out_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL held_valid: got %b want 1", out_valid); end
        checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL held_in_ready: got %b want 0000", in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", out_valid); end
        checks++; if ({out_chan, out_data} !== {2'd0, 8'h00}) begin errors++; $display("FAIL arst_word: got chan %0d data %h want chan 0 data 00", out_chan, out_data); end
        checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL arst_in_ready: got %b want 0000", in_ready); end
        in_valid = 4'h0; out_ready = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_dropped: got out_valid %b want 0", out_valid); end
    endtask

    initial begin
        errors = 0; checks = 0;
        chd = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        rst_n = 1'b1; mode = 1'b0; sel = 2'd0;
        in_data = '0; in_valid = 4'h0; out_ready = 1'b0;
        test_reset();
        test_fixed();
        test_rr();
        test_rr_sparse();
        test_back_to_back();
        test_no_grant_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
